// File: rtl/opcode_sequencer.sv
// opcode_sequencer: fetches 16-bit words from a synchronous program memory,
// forwards ordinary words to the core array as opcode + execute strobe, and
// executes the sequencer-reserved control words (0xB prefix) locally.
module opcode_sequencer #(
   parameter int ADDR_WIDTH = 8,
   parameter int LOOP_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  sync_event,
   output logic [ADDR_WIDTH-1:0] prog_addr,
   input  logic [15:0]           prog_data,
   output logic [15:0]           opcode,
   output logic                  execute,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   localparam logic [3:0] RSVD_PREFIX  = 4'hB;
   localparam logic [2:0] OP_END       = 3'b000;
   localparam logic [2:0] OP_LOOP_SET  = 3'b001;
   localparam logic [2:0] OP_LOOP_BACK = 3'b010;
   localparam logic [2:0] OP_JUMP      = 3'b011;
   localparam logic [2:0] OP_WAIT      = 3'b100;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] pc_q;         // next address to present
   logic [ADDR_WIDTH-1:0] prog_addr_q;  // address currently presented to memory
   logic [ADDR_WIDTH-1:0] dec_addr_q;   // address of the word now on prog_data
   logic                  fetch_valid_q;
   logic [LOOP_WIDTH-1:0] loop_q;
   logic [15:0]           opcode_q;
   logic                  execute_q;
   logic                  busy_q;
   logic                  done_q;

   logic                  is_rsvd_d;
   logic [2:0]            subop_d;
   logic [ADDR_WIDTH-1:0] target_d;
   logic [LOOP_WIDTH-1:0] loop_imm_d;

   // Field extraction of the word being decoded this cycle.
   always_comb begin
      is_rsvd_d  = (prog_data[15:12] == RSVD_PREFIX);
      subop_d    = prog_data[11:9];
      target_d   = prog_data[ADDR_WIDTH-1:0];
      loop_imm_d = LOOP_WIDTH'(prog_data[7:0]);
   end

   // Sequencer FSM: fetch pipeline, local control execution and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pc_q          <= '0;
         prog_addr_q   <= '0;
         dec_addr_q    <= '0;
         fetch_valid_q <= 1'b0;
         loop_q        <= '0;
         opcode_q      <= '0;
         execute_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         execute_q <= 1'b0;
         done_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q       <= S_RUN;
                  busy_q        <= 1'b1;
                  prog_addr_q   <= '0;
                  pc_q          <= ADDR_WIDTH'(1);
                  fetch_valid_q <= 1'b0;
               end
            end
            S_RUN: begin
               // Default: stream sequential addresses; the word arriving next
               // belongs to the address presented until now.
               prog_addr_q   <= pc_q;
               pc_q          <= pc_q + ADDR_WIDTH'(1);
               fetch_valid_q <= 1'b1;
               dec_addr_q    <= prog_addr_q;
               if (fetch_valid_q) begin
                  if (is_rsvd_d) begin
                     case (subop_d)
                        OP_END: begin
                           state_q       <= S_IDLE;
                           busy_q        <= 1'b0;
                           done_q        <= 1'b1;
                           fetch_valid_q <= 1'b0;
                        end
                        OP_LOOP_SET: loop_q <= loop_imm_d;
                        OP_LOOP_BACK: begin
                           if (loop_q != '0) begin
                              // Redirect immediately; the in-flight word is discarded.
                              loop_q        <= loop_q - LOOP_WIDTH'(1);
                              prog_addr_q   <= target_d;
                              pc_q          <= target_d + ADDR_WIDTH'(1);
                              fetch_valid_q <= 1'b0;
                           end
                        end
                        OP_JUMP: begin
                           prog_addr_q   <= target_d;
                           pc_q          <= target_d + ADDR_WIDTH'(1);
                           fetch_valid_q <= 1'b0;
                        end
                        OP_WAIT: begin
                           // Resume point is the word after WAIT; refetched on release.
                           state_q       <= S_WAIT;
                           pc_q          <= dec_addr_q + ADDR_WIDTH'(1);
                           fetch_valid_q <= 1'b0;
                        end
                        default: ;
                     endcase
                  end else begin
                     opcode_q  <= prog_data;
                     execute_q <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               fetch_valid_q <= 1'b0;
               if (sync_event) begin
                  // Release restarts fetching exactly like a program start.
                  state_q     <= S_RUN;
                  prog_addr_q <= pc_q;
                  pc_q        <= pc_q + ADDR_WIDTH'(1);
               end
            end
            default: begin
               state_q       <= S_IDLE;
               busy_q        <= 1'b0;
               fetch_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign prog_addr = prog_addr_q;
   assign opcode    = opcode_q;
   assign execute   = execute_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_opcode_sequencer.sv
// Directed testbench for opcode_sequencer: straight-line, jump, loop, wait,
// reset/start robustness and address wrap (on a 4-bit-address instance).
module tb_opcode_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start, start_w;
   logic        sync_event;
   logic [7:0]  prog_addr;
   logic [3:0]  prog_addr_w;
   logic [15:0] prog_data, prog_data_w;
   logic [15:0] opcode, opcode_w;
   logic        execute, execute_w;
   logic        busy, busy_w;
   logic        done, done_w;

   logic [15:0] mem  [0:255];
   logic [15:0] memw [0:15];

   int n_checks = 0;
   int n_fail   = 0;

   opcode_sequencer #(.ADDR_WIDTH(8), .LOOP_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sync_event(sync_event),
      .prog_addr(prog_addr), .prog_data(prog_data), .opcode(opcode),
      .execute(execute), .busy(busy), .done(done)
   );

   opcode_sequencer #(.ADDR_WIDTH(4), .LOOP_WIDTH(8)) dut_w (
      .clk(clk), .rst_n(rst_n), .start(start_w), .sync_event(1'b0),
      .prog_addr(prog_addr_w), .prog_data(prog_data_w), .opcode(opcode_w),
      .execute(execute_w), .busy(busy_w), .done(done_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read program memories.
   always @(posedge clk) begin
      prog_data   <= mem[prog_addr];
      prog_data_w <= memw[prog_addr_w];
   end

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      for (int i = 0; i < 16; i++) memw[i] = 16'h0000;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start_w = 1'b0; sync_event = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (prog_addr !== 8'h00) begin n_fail++; $display("FAIL reset_prog_addr: got %h expected 00", prog_addr); end
      n_checks++; if (opcode !== 16'h0000) begin n_fail++; $display("FAIL reset_opcode: got %h expected 0000", opcode); end
      n_checks++; if (execute !== 1'b0) begin n_fail++; $display("FAIL reset_execute: got %b expected 0", execute); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (prog_addr_w !== 4'h0) begin n_fail++; $display("FAIL reset_prog_addr_w: got %h expected 0", prog_addr_w); end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Straight-line program; start_at>0 also pulses start mid-run (must be ignored).
   task automatic test_straight(input string tag, input int start_at);
      logic        exp_ex, exp_done;
      logic [15:0] exp_op;
      clear_mem();
      mem[0] = 16'hC100; mem[1] = 16'hC040; mem[2] = 16'hC010; mem[3] = 16'hB000;
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         start = (k == start_at);
         @(posedge clk); #1;
         start = 1'b0;
         exp_ex   = (k >= 2 && k <= 4);
         exp_op   = (k == 2) ? 16'hC100 : (k == 3) ? 16'hC040 : 16'hC010;
         exp_done = (k == 5);
         n_checks++; if (execute !== exp_ex) begin n_fail++; $display("FAIL %s_execute cycle %0d: got %b expected %b", tag, k, execute, exp_ex); end
         if (exp_ex) begin
            n_checks++; if (opcode !== exp_op) begin n_fail++; $display("FAIL %s_opcode cycle %0d: got %h expected %h", tag, k, opcode, exp_op); end
         end
         n_checks++; if (done !== exp_done) begin n_fail++; $display("FAIL %s_done cycle %0d: got %b expected %b", tag, k, done, exp_done); end
         if (k == 3 || k == 6) begin
            n_checks++; if (busy !== (k == 3)) begin n_fail++; $display("FAIL %s_busy cycle %0d: got %b expected %b", tag, k, busy, (k == 3)); end
         end
      end
   endtask

   task automatic test_jump();
      logic exp_ex;
      clear_mem();
      mem[0] = 16'hB605; mem[1] = 16'hC011; mem[5] = 16'hC010; mem[6] = 16'hB000;
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         exp_ex = (k == 4);
         n_checks++; if (execute !== exp_ex) begin n_fail++; $display("FAIL jump_execute cycle %0d: got %b expected %b", k, execute, exp_ex); end
         if (exp_ex) begin
            n_checks++; if (opcode !== 16'hC010) begin n_fail++; $display("FAIL jump_opcode cycle %0d: got %h expected c010", k, opcode); end
         end
         n_checks++; if (done !== (k == 5)) begin n_fail++; $display("FAIL jump_done cycle %0d: got %b expected %b", k, done, (k == 5)); end
      end
   endtask

   task automatic load_loop();
      clear_mem();
      mem[0] = 16'hB203; mem[1] = 16'hC010; mem[2] = 16'hB401; mem[3] = 16'hB000;
   endtask

   task automatic test_loop();
      logic exp_ex;
      int   n_exec;
      int   n_done;
      n_exec = 0; n_done = 0;
      load_loop();
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk); #1;
         exp_ex = (k == 3 || k == 6 || k == 9 || k == 12);
         if (execute === 1'b1) n_exec++;
         if (done === 1'b1) n_done++;
         n_checks++; if (execute !== exp_ex) begin n_fail++; $display("FAIL loop_execute cycle %0d: got %b expected %b", k, execute, exp_ex); end
         if (exp_ex) begin
            n_checks++; if (opcode !== 16'hC010) begin n_fail++; $display("FAIL loop_opcode cycle %0d: got %h expected c010", k, opcode); end
         end
         n_checks++; if (done !== (k == 14)) begin n_fail++; $display("FAIL loop_done cycle %0d: got %b expected %b", k, done, (k == 14)); end
      end
      n_checks++; if (n_exec != 4) begin n_fail++; $display("FAIL loop_body_count: got %0d expected 4", n_exec); end
      n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL loop_done_count: got %0d expected 1", n_done); end
      n_checks++; if (dut.loop_q !== 8'h00) begin n_fail++; $display("FAIL loop_counter_end: got %h expected 00", dut.loop_q); end
   endtask

   task automatic test_wait();
      logic exp_ex;
      clear_mem();
      mem[0] = 16'hB800; mem[1] = 16'hC010; mem[2] = 16'hB000;
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         // A pulse sampled on the WAIT-decode edge (k==2) must not release.
         sync_event = (k == 2 || k == 10);
         @(posedge clk); #1;
         sync_event = 1'b0;
         exp_ex = (k == 12);
         n_checks++; if (execute !== exp_ex) begin n_fail++; $display("FAIL wait_execute cycle %0d: got %b expected %b", k, execute, exp_ex); end
         if (exp_ex) begin
            n_checks++; if (opcode !== 16'hC010) begin n_fail++; $display("FAIL wait_opcode cycle %0d: got %h expected c010", k, opcode); end
         end
         n_checks++; if (done !== (k == 13)) begin n_fail++; $display("FAIL wait_done cycle %0d: got %b expected %b", k, done, (k == 13)); end
         if (k == 6) begin
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wait_busy: got %b expected 1", busy); end
         end
      end
   endtask

   task automatic test_reset_abort();
      load_loop();
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      n_checks++; if (execute !== 1'b1) begin n_fail++; $display("FAIL abort_pre_execute: got %b expected 1", execute); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (execute !== 1'b0) begin n_fail++; $display("FAIL abort_execute: got %b expected 0", execute); end
      n_checks++; if (opcode !== 16'h0000) begin n_fail++; $display("FAIL abort_opcode: got %h expected 0000", opcode); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
      n_checks++; if (prog_addr !== 8'h00) begin n_fail++; $display("FAIL abort_prog_addr: got %h expected 00", prog_addr); end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done cycle %0d: got %b expected 0", k, done); end
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_after cycle %0d: got done=%b busy=%b expected 0 0", k, done, busy); end
      end
   endtask

   task automatic test_wrap();
      logic        exp_ex;
      logic [15:0] exp_op;
      clear_mem();
      memw[0] = 16'hC030; memw[1] = 16'hB404; memw[2] = 16'hB201; memw[3] = 16'hB60E;
      memw[4] = 16'hB000; memw[14] = 16'hC020; memw[15] = 16'hC010;
      start_w = 1'b1; @(posedge clk); #1; start_w = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         @(posedge clk); #1;
         exp_ex = (k == 2 || k == 7 || k == 8 || k == 9);
         exp_op = (k == 7) ? 16'hC020 : (k == 8) ? 16'hC010 : 16'hC030;
         if (k == 5 || k == 6 || k == 7) begin
            n_checks++;
            if (prog_addr_w !== ((k == 5) ? 4'd14 : (k == 6) ? 4'd15 : 4'd0)) begin
               n_fail++;
               $display("FAIL wrap_prog_addr cycle %0d: got %h expected %h", k, prog_addr_w, ((k == 5) ? 4'd14 : (k == 6) ? 4'd15 : 4'd0));
            end
         end
         n_checks++; if (execute_w !== exp_ex) begin n_fail++; $display("FAIL wrap_execute cycle %0d: got %b expected %b", k, execute_w, exp_ex); end
         if (exp_ex) begin
            n_checks++; if (opcode_w !== exp_op) begin n_fail++; $display("FAIL wrap_opcode cycle %0d: got %h expected %h", k, opcode_w, exp_op); end
         end
         n_checks++; if (done_w !== (k == 12)) begin n_fail++; $display("FAIL wrap_done cycle %0d: got %b expected %b", k, done_w, (k == 12)); end
      end
   endtask

   initial begin
      clear_mem();
      test_reset();
      test_straight("straight", 0);
      repeat (2) @(posedge clk);
      #1;
      test_jump();
      repeat (2) @(posedge clk);
      #1;
      test_loop();
      repeat (2) @(posedge clk);
      #1;
      test_wait();
      repeat (2) @(posedge clk);
      #1;
      test_reset_abort();
      test_straight("start_ignored", 3);
      repeat (2) @(posedge clk);
      #1;
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
